// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus a four-state qualification FSM that turns a bouncy async input into a clean level.
// Optional rise/fall edge pulses are built only when DEBOUNCE_EDGE_PULSE_EN is defined.
module input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam state_t ST_INIT = INIT_LEVEL ? ST_HI : ST_LO;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;

    // Synchronizer and FSM next-state; a reversal is checked before the count limit.
    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = '0;
        dout_d  = dout_q;
        case (state_q)
            ST_LO: begin
                if (s2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!s2_q) begin
                    state_d = ST_LO;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (!s2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (s2_q) begin
                    state_d = ST_HI;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    dout_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q    <= INIT_LEVEL;
            s2_q    <= INIT_LEVEL;
            state_q <= ST_INIT;
            cnt_q   <= '0;
            dout_q  <= INIT_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses mark a committed level change; reset never creates one.
    always_comb begin
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: directed tables, corner sequences and random stimulus against a run-length model.
module tb_input_debouncer;

    localparam int unsigned N = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam logic PULSE = 1'b1;
`else
    localparam logic PULSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic din;
    logic dout, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.STABLE_CYCLES(N), .INIT_LEVEL(1'b0)) dut (
        .clk  (clk),
        .rstn (rstn),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference: din reaches the FSM two edges late; dout flips after N consecutive disagreeing samples.
    logic dly[$];
    logic run[$];
    logic m_dout, m_rise, m_fall, m_busy;

    task automatic model_reset();
        dly = {1'b0, 1'b0};
        run = {};
        m_dout = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic s;
        s = dly.pop_front();
        dly.push_back(din);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_dout) begin
            run.push_back(s);
            if (run.size() == int'(N)) begin
                m_dout = s;
                m_rise = s;
                m_fall = ~s;
                run = {};
            end
        end else begin
            run = {};
        end
        m_busy = (run.size() != 0);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_dout", dout, m_dout);
        chk("model_rise", rise, m_rise & PULSE);
        chk("model_fall", fall, m_fall & PULSE);
        chk("model_busy", busy, m_busy);
    endtask

    task automatic drive_tick(input logic v);
        @(negedge clk);
        din = v;
        tick();
    endtask

    typedef struct {
        logic din;
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int rises, falls, first_hi, hi_cycles;
        logic [5:0] bounce;

        // Clean rise (edges 0..7) then clean fall (edges 0..7)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rstn = 1'b0;
        din  = 1'b0;
        model_reset();
        #3;
        chk("reset_dout", dout, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rise", rise, 1'b0);
        chk("reset_fall", fall, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        drive_tick(1'b0);
        drive_tick(1'b0);

        for (int i = 0; i < 16; i++) begin
            drive_tick(tbl[i].din);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
            chk($sformatf("tbl%0d_rise", i), rise, tbl[i].rise & PULSE);
            chk($sformatf("tbl%0d_fall", i), fall, tbl[i].fall & PULSE);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
        end

        // Short glitch of three cycles must be rejected
        rises = 0;
        hi_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            drive_tick((i < 3) ? 1'b1 : 1'b0);
            if (rise) rises++;
            if (dout) hi_cycles++;
        end
        chk("glitch_dout_high_seen", hi_cycles != 0, 1'b0);
        chk("glitch_rise_seen", rises != 0, 1'b0);
        chk("glitch_busy_end", busy, 1'b0);

        // Bounce 1,0,1,1,0,1 then hold: dout rises 5 edges after the last 0->1 (edge 10)
        bounce = 6'b101101;
        rises = 0;
        first_hi = -1;
        for (int i = 0; i < 20; i++) begin
            drive_tick((i < 6) ? bounce[5 - i] : 1'b1);
            if (rise) rises++;
            if (dout && first_hi < 0) first_hi = i;
        end
        chk("bounce_rise_edge", first_hi == 10, 1'b1);
        chk("bounce_rise_count", rises == (PULSE ? 1 : 0), 1'b1);

        // Settle low, then reset between edges 3 and 4 of a rise
        for (int i = 0; i < 10; i++) drive_tick(1'b0);
        for (int i = 0; i < 4; i++) drive_tick(1'b1);
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset_dout", dout, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_rise", rise, 1'b0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        first_hi = -1;
        rises = 0;
        falls = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rise) rises++;
            if (fall) falls++;
            if (dout && first_hi < 0) first_hi = i;
        end
        chk("post_reset_rise_edge", first_hi == 6, 1'b1);
        chk("post_reset_rise_count", rises == (PULSE ? 1 : 0), 1'b1);
        chk("post_reset_fall_count", falls == 0, 1'b1);

        // Random runs of held levels, checked every cycle against the model
        for (int r = 0; r < 400; r++) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int j = 0; j < len; j++) begin
                drive_tick(v);
                chk("rand_excl", rise & fall, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Cleans a raw, asynchronous, bouncy single-bit input (push-button, switch, external strobe) into a glitch-free level that is safe to register in the `clk` domain. It sits directly upstream of the data-capture flip-flop stage, whose `d` input it drives. It optionally produces single-cycle rise and fall pulses for downstream event logic.

## Interface

Parameters:
- `STABLE_CYCLES`, default 16: number of consecutive synchronized samples that must disagree with `dout` before `dout` changes. Must be ≥ 2.
- `INIT_LEVEL`, default 1'b0: reset level of `dout` and of the synchronizer flops.
- Localparam `CNT_W` = $clog2(STABLE_CYCLES): counter width. Not user-settable.

Ports:
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rstn`  input  1  reset, asynchronous assert, active-low. Deassertion must be synchronous to `clk` at system level.
- `din`  input  1  raw asynchronous input; may glitch at any time.
- `dout`  output  1  debounced level; registered.
- `rise`  output  1  one-cycle pulse on a `dout` 0→1 change; registered.
- `fall`  output  1  one-cycle pulse on a `dout` 1→0 change; registered.
- `busy`  output  1  high while a candidate change is being qualified (CHK states); registered.

## Operation

- Two-flop synchronizer: `s1 <= din`, `s2 <= s1`. Only `s2` feeds the FSM.
- FSM states:
  - `ST_LO`: `dout`=0.
  - `CHK_HI`: `dout`=0, candidate high.
  - `ST_HI`: `dout`=1.
  - `CHK_LO`: `dout`=1, candidate low.
- `ST_LO`, `s2`=1 → `CHK_HI`, `cnt`<=1. Otherwise stay, `cnt`<=0.
- `CHK_HI`:
  - `s2`=0 → `ST_LO`, `cnt`<=0 (glitch rejected).
  - `s2`=1 and `cnt`==STABLE_CYCLES−1 → `ST_HI`, `dout`<=1, `rise`<=1, `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
- `ST_HI` / `CHK_LO`: mirror of the above with levels inverted; `fall` pulses on entry to `ST_HI`→`ST_LO` completion.
- `rise`/`fall` are high for exactly one cycle and are never high together.
- `busy` = 1 exactly when the state is `CHK_HI` or `CHK_LO`.
- `cnt` never exceeds STABLE_CYCLES−1. No wrap-around is possible.

## Timing

- Reset (`rstn`=0, immediate, no clock needed):
  - `s1`, `s2`, `dout` = INIT_LEVEL.
  - State = `ST_HI` if INIT_LEVEL=1, else `ST_LO`.
  - `cnt`=0, `rise`=`fall`=`busy`=0.
- Latency: if `din` changes before edge k and stays stable, `dout` changes after edge k+1+STABLE_CYCLES. `s2` must match the new value on STABLE_CYCLES consecutive edges (k+2 … k+1+STABLE_CYCLES).
- Minimum accepted pulse width: STABLE_CYCLES cycles. Any shorter excursion leaves `dout` unchanged; `busy` is high during it.
- A reversal on the same edge that `cnt` reaches the limit is a rejection: the reversal is checked first.
- Reset mid-qualification: the candidate is discarded and `dout` returns to INIT_LEVEL even if the input had been qualified the opposite way. No `rise`/`fall` is produced by reset.
- First edge after reset release behaves as a normal `ST_*` cycle.

## Configuration

- Macro `DEBOUNCE_EDGE_PULSE_EN`:
  - Defined: `rise`/`fall` registers are built as described above.
  - Undefined: `rise` and `fall` are driven constant 0 and their flops are not built; `dout`, `busy` and latency are unchanged.

## Test plan

All scenarios use STABLE_CYCLES=4, INIT_LEVEL=0, macro defined; `din` is changed just before edge 0.

- Clean rise: `din` 0→1 held → `dout` goes 1 after edge 5; `rise`=1 for that one cycle only; `busy`=1 after edges 2–4.
- Short glitch: `din`=1 for 3 cycles, then 0 → `dout` stays 0; `rise` never asserts; `busy` returns to 0 after `s2` falls.
- Bounce then settle: `din` pattern 1,0,1,1,0,1 then held 1 → `dout` rises exactly 5 edges after the last 0→1 transition; exactly one `rise` pulse.
- Clean fall from high: `din` 1→0 held → `dout` goes 0 after edge 5; one `fall` pulse; `rise` stays 0.
- Async reset mid-check: assert `rstn`=0 between edges 3 and 4 of a rise → `dout`, `busy` and `cnt` are 0 immediately (no clock); after release with `din` still 1, `dout` rises 6 edges later.
- Macro off: repeat the clean rise → `dout` timing is identical; `rise` and `fall` stay 0 throughout.
